// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared constants and types for the FIFO stream reader
// Contents:
//   RD_LAT     read latency of the upstream FIFO in cycles (only 1 is handled)
//   SKID_DEPTH number of words the skid buffer can hold
//   occ_t      occupancy count type wide enough for 0..SKID_DEPTH
package fifo_stream_reader_pkg;
  localparam int RD_LAT     = 1;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  typedef logic [OCC_W-1:0] occ_t;
endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// rtl/fifo_stream_reader_skid_buf.sv - 2-entry register skid buffer with push/pop
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data into the tail entry this cycle
//   push_data   word to store
//   pop         retire the head entry this cycle
//   head_data   contents of the head entry
//   cnt         number of stored words (0..2)
module stream_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output occ_t             cnt
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [WIDTH-1:0] mem_d [SKID_DEPTH];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  occ_t             cnt_q, cnt_d;

  // Push and pop are independent: a simultaneous push/pop moves both
  // pointers and leaves the count unchanged.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    cnt_d = cnt_q + occ_t'(push) - occ_t'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign cnt       = cnt_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read port to valid/ready stream adapter
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          allow new FIFO reads (buffered/in-flight words still drain)
//   fifo_empty  FIFO empty flag
//   fifo_re     FIFO read enable
//   fifo_rdata  FIFO read data, valid the cycle after fifo_re
//   m_valid     stream valid (skid buffer non-empty)
//   m_ready     consumer ready
//   m_data      stream data (skid buffer head)
//   word_cnt    stream handshakes since reset, wrapping
//   busy        buffer non-empty or a read in flight
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_re,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNTW-1:0]  word_cnt,
  output logic             busy
);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("fifo_stream_reader only supports a FIFO read latency of 1");
  end

  logic            inflight_q, inflight_d;
  logic [CNTW-1:0] word_cnt_q, word_cnt_d;
  occ_t            buf_cnt;
  logic            pop;
  logic [2:0]      occ_next;

  stream_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head_data (m_data),
    .cnt       (buf_cnt)
  );

  assign m_valid = (buf_cnt != '0);
  assign pop     = m_valid & m_ready;

  // Occupancy after this cycle, counting the word already in flight, must
  // leave room for the word a new read would return next cycle.
  always_comb begin
    occ_next   = 3'({1'b0, buf_cnt}) + {2'b0, inflight_q} - {2'b0, pop};
    fifo_re    = en & ~fifo_empty & (occ_next < 3'd2);
    inflight_d = fifo_re;
    word_cnt_d = word_cnt_q + CNTW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
  assign busy     = m_valid | inflight_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
  localparam int WIDTH = 32;
  localparam int CNTW  = 16;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             fifo_empty;
  logic             fifo_re;
  logic [WIDTH-1:0] fifo_rdata;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [CNTW-1:0]  word_cnt;
  logic             busy;

  fifo_stream_reader #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .word_cnt   (word_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFO: queue of words, registered read data, empty flag.
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      fifo_rdata <= '0;
      fifo_empty <= 1'b1;
    end else if (fifo_re) begin
      if (fifo_q.size() != 0) fifo_rdata <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic fifo_write(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Stream monitor, sampled late in each cycle just before the rising edge.
  int               rd_cnt = 0;
  int               hs_cnt = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;

  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      rd_cnt     = 0;
      hs_cnt     = 0;
      prev_stall = 1'b0;
    end else begin
      chk("occupancy_le_2", 32'((rd_cnt - hs_cnt) <= 2), 32'd1);
      if (busy !== ((rd_cnt - hs_cnt) != 0)) chk("busy_vs_outstanding", 32'(busy), 32'((rd_cnt - hs_cnt) != 0));
      if (fifo_re) chk("re_while_empty", 32'(fifo_empty), 32'd0);
      if (prev_stall) begin
        chk("stall_valid_held", 32'(m_valid), 32'd1);
        chk("stall_data_held", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        chk("word_cnt_track", 32'(word_cnt), 32'(hs_cnt[CNTW-1:0]));
        if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
        else chk("stream_order", m_data, exp_q.pop_front());
        hs_cnt++;
      end
      if (fifo_re) rd_cnt++;
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
    end
  end

  task automatic wait_drain(input string tag, input int max_cycles);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < max_cycles) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(k < max_cycles), 32'd1);
  endtask

  int rd0;
  int hs0;
  int nwr;

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_fifo_re", 32'(fifo_re), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: A0..A3 stream out back to back.
    @(negedge clk);
    for (int i = 0; i < 4; i++) fifo_write(32'hA0 + 32'(i));
    en = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("basic_first_re", 32'(fifo_re), 32'd1);
    chk("basic_valid_c0", 32'(m_valid), 32'd0);
    @(negedge clk); #1;
    chk("basic_valid_c1", 32'(m_valid), 32'd0);
    @(negedge clk); #1;
    chk("basic_first_valid", 32'(m_valid), 32'd1);
    chk("basic_first_data", m_data, 32'hA0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      chk("basic_consecutive", 32'(m_valid), 32'd1);
      chk("basic_data", m_data, 32'hA0 + 32'(i));
    end
    @(negedge clk); #1;
    chk("basic_valid_end", 32'(m_valid), 32'd0);
    chk("basic_word_cnt", 32'(word_cnt), 32'd4);
    chk("basic_busy_end", 32'(busy), 32'd0);

    // Backpressure: 8 words, consumer stalled.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_write(32'hB0 + 32'(i));
    repeat (6) @(negedge clk);
    #1;
    chk("bp_re_low", 32'(fifo_re), 32'd0);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", m_data, 32'hB0);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_fifo_left", 32'(fifo_q.size()), 32'd6);
    m_ready = 1'b1;
    wait_drain("bp_drain", 14);
    chk("bp_word_cnt", 32'(word_cnt), 32'd12);

    // Random ready with interleaved random writes.
    nwr = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      if (nwr < 64 && $urandom_range(0, 1) == 1) begin
        fifo_write($urandom());
        nwr++;
      end
    end
    while (nwr < 64) begin
      fifo_write($urandom());
      nwr++;
    end
    @(negedge clk);
    m_ready = 1'b1;
    wait_drain("rand_drain", 200);
    chk("rand_word_cnt", 32'(word_cnt), 32'd76);

    // Empty edge: a single word into an empty FIFO.
    @(negedge clk);
    rd0 = rd_cnt;
    hs0 = hs_cnt;
    fifo_write(32'hE1);
    repeat (6) @(negedge clk);
    #1;
    chk("empty_one_read", 32'(rd_cnt - rd0), 32'd1);
    chk("empty_one_hs", 32'(hs_cnt - hs0), 32'd1);
    chk("empty_valid_low", 32'(m_valid), 32'd0);
    chk("empty_re_low", 32'(fifo_re), 32'd0);

    // en gating: en high for exactly the cycle of one read.
    en = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(32'hF0 + 32'(i));
    @(negedge clk);
    hs0 = hs_cnt;
    en  = 1'b1;
    #1;
    chk("en_re_issued", 32'(fifo_re), 32'd1);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("en_re_blocked", 32'(fifo_re), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("en_inflight_delivered", 32'(hs_cnt - hs0), 32'd1);
    en = 1'b1;
    wait_drain("en_resume_drain", 20);

    // Reset mid-stream with data buffered and a read in flight.
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(32'hC0 + 32'(i));
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_valid", 32'(m_valid), 32'd0);
    chk("rst_mid_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fifo_write(32'hD0);
    fifo_write(32'hD1);
    m_ready = 1'b1;
    wait_drain("rst_restart_drain", 20);
    chk("rst_restart_word_cnt", 32'(word_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] watchdog FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
